// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the memory copy DMA
package dma_pkg;

    localparam int DMA_LEN_W   = 16;
    localparam int DMA_ADDR_W  = 32;
    localparam int WORD_STRIDE = 4;

    // Two-bit state encoding shared by the controller and the bus driver.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } dma_state_t;

    // A byte address is usable for a word access only when its two low bits are clear.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - shared data-bus bundle between the DMA and memory
interface mem_copy_dma_if #(
    parameter int ADDR_W = 32
);
    logic              grant;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       Write_data;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Read_data;

    // DMA side: drives the strobes, sees grant and read data.
    modport master (
        input  grant,
        input  Read_data,
        output Address,
        output Write_data,
        output MemRead,
        output MemWrite
    );

    // Memory/arbiter side.
    modport slave (
        output grant,
        output Read_data,
        input  Address,
        input  Write_data,
        input  MemRead,
        input  MemWrite
    );
endinterface

// File: rtl/dma_bus_drv.sv
// rtl/dma_bus_drv.sv - data-bus output mux driven from controller state
module dma_bus_drv
    import dma_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W
) (
    input  dma_state_t        state,
    input  logic              grant,
    input  logic [ADDR_W-1:0] src_ptr,
    input  logic [ADDR_W-1:0] dst_ptr,
    input  logic [31:0]       data_buf,
    output logic [ADDR_W-1:0] Address,
    output logic [31:0]       Write_data,
    output logic              MemRead,
    output logic              MemWrite
);

    // Only one strobe per cycle, and address/data are forced to zero when idle or stalled.
    always_comb begin
        Address    = '0;
        Write_data = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        if (grant) begin
            case (state)
                ST_READ: begin
                    MemRead = 1'b1;
                    Address = src_ptr;
                end
                ST_WRITE: begin
                    MemWrite   = 1'b1;
                    Address    = dst_ptr;
                    Write_data = data_buf;
                end
                default: begin
                    MemRead  = 1'b0;
                    MemWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-granular memory-to-memory copy engine with bus-grant stalls
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int LEN_W  = DMA_LEN_W,
    parameter int ADDR_W = DMA_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    mem_copy_dma_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              irq,
    input  logic              irq_clr
);

    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(WORD_STRIDE);
    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

    dma_state_t        state;
    dma_state_t        state_d;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [31:0]       data_buf;
    logic              misaligned;
    logic              accept;

    assign misaligned = !is_word_aligned(src_addr[1:0]) || !is_word_aligned(dst_addr[1:0]);
    assign accept     = (state == ST_IDLE) && start;

    // FIN is a single-cycle state, so done is simply the FIN decode; busy covers everything off IDLE.
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    // State register; reset aborts any copy in flight without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: misaligned or empty requests go straight to FIN without touching the bus.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (misaligned || (len == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (bus.grant) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.grant) begin
                    state_d = (remaining == LEN_ONE) ? ST_FIN : ST_READ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch the request, then advance pointers only on granted cycles (wrapping naturally).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_buf  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        err       <= misaligned;
                    end
                end
                ST_READ: begin
                    if (bus.grant) begin
                        data_buf <= bus.Read_data;
                        src_ptr  <= src_ptr + STRIDE;
                    end
                end
                ST_WRITE: begin
                    if (bus.grant) begin
                        dst_ptr   <= dst_ptr + STRIDE;
                        remaining <= remaining - LEN_ONE;
                    end
                end
                default: begin
                    err <= err;
                end
            endcase
        end
    end

    // Sticky interrupt set on FIN; a same-cycle clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end else if (state == ST_FIN) begin
            irq <= 1'b1;
        end
    end

    dma_bus_drv #(
        .ADDR_W(ADDR_W)
    ) u_bus_drv (
        .state      (state),
        .grant      (bus.grant),
        .src_ptr    (src_ptr),
        .dst_ptr    (dst_ptr),
        .data_buf   (data_buf),
        .Address    (bus.Address),
        .Write_data (bus.Write_data),
        .MemRead    (bus.MemRead),
        .MemWrite   (bus.MemWrite)
    );

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - scoreboard bench for mem_copy_dma
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic        irq;
    logic        irq_clr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    int          exp_done[$];
    logic [63:0] wr_e;

    logic [31:0] mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    mem_copy_dma_if #(.ADDR_W(32)) bus ();

    mem_copy_dma #(
        .LEN_W  (16),
        .ADDR_W (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .irq      (irq),
        .irq_clr  (irq_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.MemWrite) mem[bus.Address[9:2]] <= bus.Write_data;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    always_comb begin
        bus.Read_data = 32'h0;
        if (bus.MemRead) bus.Read_data = mem[bus.Address[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h want nothing (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a strobe or done.
    always @(negedge clk) begin
        check("strobe_excl", 32'(bus.MemRead & bus.MemWrite), 32'h0);
        if (!bus.MemRead && !bus.MemWrite) check("addr_idle", bus.Address, 32'h0);
        if (!bus.MemWrite) check("wdata_idle", bus.Write_data, 32'h0);
        if (!bus.grant) check("stall_strobe", 32'({bus.MemRead, bus.MemWrite}), 32'h0);
        if (bus.MemRead) begin
            if (exp_rd.size() == 0) unexpected("unexp_read", bus.Address);
            else check("rd_addr", bus.Address, exp_rd.pop_front());
        end
        if (bus.MemWrite) begin
            if (exp_wr.size() == 0) unexpected("unexp_write", bus.Address);
            else begin
                wr_e = exp_wr.pop_front();
                check("wr_addr", bus.Address, wr_e[63:32]);
                check("wr_data", bus.Write_data, wr_e[31:0]);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) unexpected("unexp_done", 32'(cyc));
            else check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_we = 1'b1;
        pre_idx = idx;
        pre_data = data;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic push_rw(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd);
        exp_rd.push_back(ra);
        exp_wr.push_back({wa, wd});
    endtask

    // done_off counts the start cycle as 1: an N-word copy ends at start cycle + 2N+1.
    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int done_off);
        if (done_off >= 0) exp_done.push_back(cyc + done_off);
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        len = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_done.size() + exp_rd.size() + exp_wr.size()) != 0 && n < 60) begin
            tick();
            n++;
        end
        if ((exp_done.size() + exp_rd.size() + exp_wr.size()) != 0) begin
            unexpected(name, 32'(exp_done.size() + exp_rd.size() + exp_wr.size()));
            exp_done.delete();
            exp_rd.delete();
            exp_wr.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        irq_clr = 1'b0;
        pre_we = 1'b0;
        pre_idx = '0;
        pre_data = '0;
        bus.grant = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_strobes", 32'({bus.MemRead, bus.MemWrite}), 32'h0);
        check("rst_addr", bus.Address, 32'h0);
        reset = 1'b1;
        tick();

        // Basic 3-word copy 0x0 -> 0x100.
        preload(8'd0, 32'h64);
        preload(8'd1, 32'd10);
        preload(8'd2, 32'd10);
        push_rw(32'h0, 32'h100, 32'h64);
        push_rw(32'h4, 32'h104, 32'd10);
        push_rw(32'h8, 32'h108, 32'd10);
        launch(32'h0, 32'h100, 16'd3, 7);
        check("basic_busy", 32'(busy), 32'h1);
        wait_drain("basic_drain");
        check("basic_m0", mem[64], 32'h64);
        check("basic_m1", mem[65], 32'd10);
        check("basic_m2", mem[66], 32'd10);
        check("basic_irq", 32'(irq), 32'h1);
        check("basic_err", 32'(err), 32'h0);

        // Same copy, grant withheld for 5 cycles during the second READ.
        preload(8'd64, 32'h0);
        preload(8'd65, 32'h0);
        preload(8'd66, 32'h0);
        push_rw(32'h0, 32'h100, 32'h64);
        push_rw(32'h4, 32'h104, 32'd10);
        push_rw(32'h8, 32'h108, 32'd10);
        launch(32'h0, 32'h100, 16'd3, 12);
        tick();
        tick();
        bus.grant = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.grant = 1'b1;
        wait_drain("stall_drain");
        check("stall_m0", mem[64], 32'h64);
        check("stall_m1", mem[65], 32'd10);
        check("stall_m2", mem[66], 32'd10);

        // Misaligned source: rejected, err set, no bus traffic.
        launch(32'h2, 32'h100, 16'd3, 1);
        wait_drain("misalign_drain");
        check("misalign_err", 32'(err), 32'h1);

        // Zero length: done two cycles in, no bus traffic, err cleared by the accepted start.
        launch(32'h0, 32'h100, 16'd0, 1);
        wait_drain("zero_drain");
        check("zero_err", 32'(err), 32'h0);

        // Start while busy is ignored: writes stay at the first dst.
        push_rw(32'h0, 32'h200, 32'h64);
        push_rw(32'h4, 32'h204, 32'd10);
        launch(32'h0, 32'h200, 16'd2, 5);
        tick();
        start = 1'b1;
        src_addr = 32'h40;
        dst_addr = 32'h300;
        len = 16'd5;
        tick();
        start = 1'b0;
        wait_drain("busy_start_drain");
        check("busy_start_m0", mem[128], 32'h64);
        check("busy_start_m1", mem[129], 32'd10);

        // Reset during the WRITE of word 2 of a 4-word copy.
        preload(8'd96, 32'hDEAD_BEEF);
        preload(8'd97, 32'hDEAD_BEEF);
        push_rw(32'h0, 32'h180, 32'h64);
        exp_rd.push_back(32'h4);
        launch(32'h0, 32'h180, 16'd4, -1);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rstmid_strobes", 32'({bus.MemRead, bus.MemWrite}), 32'h0);
        check("rstmid_addr", bus.Address, 32'h0);
        check("rstmid_wdata", bus.Write_data, 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_irq", 32'(irq), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("rstmid_queues", 32'(exp_rd.size() + exp_wr.size()), 32'h0);
        check("rstmid_m0", mem[96], 32'h64);
        check("rstmid_m1", mem[97], 32'hDEAD_BEEF);

        // Source wraps from 0xFFFFFFFC to 0x0; irq_clr coincides with FIN.
        preload(8'd255, 32'hA5A5_0001);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        push_rw(32'hFFFF_FFFC, 32'h80, 32'hA5A5_0001);
        push_rw(32'h0, 32'h84, 32'h64);
        launch(32'hFFFF_FFFC, 32'h80, 16'd2, 5);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_fin_done", 32'(done), 32'h1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("wrap_irq_clr", 32'(irq), 32'h0);
        wait_drain("wrap_drain");
        check("wrap_irq_after", 32'(irq), 32'h0);
        check("wrap_err", 32'(err), 32'h0);
        check("wrap_m0", mem[32], 32'hA5A5_0001);
        check("wrap_m1", mem[33], 32'h64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter LEN_W, default 16, width of the word-count field.
REQ-002 Parameter ADDR_W, default 32, width of byte addresses on the data bus.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_W  byte address of first source word; sampled with start.
REQ-007 dst_addr  input  ADDR_W  byte address of first destination word; sampled with start.
REQ-008 len  input  LEN_W  number of 32-bit words to copy; sampled with start.
REQ-009 grant  input  1  bus grant from the CPU-side arbiter; 1 = this block owns the data bus this cycle.
REQ-010 Address  output  ADDR_W  data-bus byte address.
REQ-011 Write_data  output  32  data-bus write data.
REQ-012 MemRead  output  1  data-bus read strobe; Read_data is valid in the same cycle.
REQ-013 MemWrite  output  1  data-bus write strobe; the write commits at the next posedge.
REQ-014 Read_data  input  32  data-bus read data; combinational response to Address/MemRead.
REQ-015 busy  output  1  high from the cycle after an accepted start until the return to IDLE.
REQ-016 done  output  1  single-cycle pulse when a copy ends, whether it succeeds or aborts.
REQ-017 err  output  1  sticky flag, set when a copy is rejected for misalignment; cleared by the next accepted start.
REQ-018 irq  output  1  sticky level, set with done; cleared by irq_clr.
REQ-019 irq_clr  input  1  single-cycle clear of irq; it takes priority over a same-cycle set.

Function
REQ-020 The state machine SHALL have four states, IDLE, READ, WRITE and FIN, and SHALL encode them in two bits.
REQ-021 In IDLE, start=1 SHALL latch src_addr, dst_addr and len into src_ptr, dst_ptr and remaining, and clear err.
REQ-022 When the latched len=0, the block SHALL go IDLE->FIN and issue no bus access.
REQ-023 When src_addr[1:0]!=0 or dst_addr[1:0]!=0, the block SHALL go IDLE->FIN, set err and issue no bus access.
REQ-024 Otherwise the block SHALL go IDLE->READ.
REQ-025 In READ with grant=1, the block SHALL drive MemRead=1 and Address=src_ptr, capture Read_data into buf at the posedge, add 4 to src_ptr, and go to WRITE.
REQ-026 In WRITE with grant=1, the block SHALL drive MemWrite=1, Address=dst_ptr and Write_data=buf, add 4 to dst_ptr, and decrement remaining.
REQ-027 From WRITE, the block SHALL go to FIN when remaining was 1, and to READ otherwise.
REQ-028 In READ or WRITE with grant=0, the block SHALL drive MemRead=0 and MemWrite=0, hold its state, and leave all pointers and buf unchanged.
REQ-029 In FIN, the block SHALL assert done for exactly one cycle, set irq, and return to IDLE on the following edge.
REQ-030 A granted word SHALL take 2 cycles; an N-word copy with constant grant SHALL take 2N+2 cycles from the start edge to the done cycle inclusive.
REQ-031 Pointer arithmetic SHALL be modulo 2^ADDR_W; wrap from 0xFFFFFFFC to 0x0 is legal and SHALL not be flagged.
REQ-032 The copy SHALL proceed strictly forward; overlapping regions SHALL get no special handling.
REQ-033 A start pulse outside IDLE SHALL be ignored, with no change to state or to the latched parameters.
REQ-034 MemRead and MemWrite SHALL never be high in the same cycle, and SHALL both be 0 in IDLE and FIN.
REQ-035 Address and Write_data SHALL be 0 whenever their strobe is low.

Reset
REQ-036 Assertion of reset (reset=0) SHALL immediately force IDLE and clear src_ptr, dst_ptr, remaining, buf, busy, done, err and irq; all bus outputs SHALL go to 0.
REQ-037 A reset during READ or WRITE SHALL abort the copy; words already written SHALL remain in memory, and no done pulse SHALL follow.

Structure
REQ-038 The state encoding, the word stride (4) and the default LEN_W/ADDR_W SHALL reside in the shared package dma_pkg.
REQ-039 The bus-output mux SHALL be implemented as the sub-module dma_bus_drv, with inputs state, grant, src_ptr, dst_ptr and buf, and outputs Address, Write_data, MemRead and MemWrite.

Verification
REQ-040 Basic copy: memory words 0..2 = 0x64, 10, 10; start with src=0x0, dst=0x100, len=3, grant=1 -> the words at 0x100..0x108 equal 0x64, 10, 10, done appears 8 cycles after the start edge, and irq=1.
REQ-041 Grant stall: same copy with grant=0 for 5 cycles during the second READ -> no strobe in those cycles, identical final memory, and done 13 cycles after the start edge.
REQ-042 Misalignment: start with src=0x2 -> err=1, done pulse, zero MemRead/MemWrite cycles.
REQ-043 Zero length and ignored start: len=0 -> done 2 cycles after the start edge with no bus access; a second start issued while busy -> ignored, and the latched dst is unchanged.
REQ-044 Reset mid-copy: reset driven low in the WRITE state of word 2 of a 4-word copy -> all outputs 0 at once, only word 1 written, and no done pulse.
REQ-045 Wrap and irq priority: src=0xFFFFFFFC with len=2 -> second read at 0x0; irq_clr asserted in the same cycle as FIN -> irq=0.
